// File: rtl/peridot_phy_txd_pkg.sv
// Shared UART PHY constants and divisor helper for peridot_phy_txd.
// The same constants are used by the matching receiver PHY.
package peridot_phy_txd_pkg;

    localparam int   UART_FRAME_BITS = 10;
    localparam int   UART_DIV_WIDTH  = 12;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef logic [UART_DIV_WIDTH-1:0] div_t;
    typedef logic [3:0]                bitcnt_t;

    // Clocks per bit minus one; the result must fit 1..4095.
    function automatic int uart_divnum(input int clock_frequency, input int uart_baudrate);
        return clock_frequency / uart_baudrate - 1;
    endfunction

endpackage

// File: rtl/peridot_phy_txd.sv
// 8N1 UART transmitter PHY with an Avalon-ST ready/valid byte sink.
// Define PERIDOT_PHY_TXD_HOLDBUF_EN to add a one-entry holding buffer ahead of the shifter.
module peridot_phy_txd
    import peridot_phy_txd_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUDRATE   = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       txd
);

    localparam div_t CLOCK_DIVNUM = div_t'(uart_divnum(CLOCK_FREQUENCY, UART_BAUDRATE));

    // Handshake: a byte transfers on any rising clk edge where in_valid && in_ready;
    // in_data is sampled only on that edge and in_valid may change freely otherwise.
    bitcnt_t    r_bitcnt;
    div_t       r_divcnt;
    logic [7:0] r_shift;
    logic       r_txd;

    logic       w_frame_end;
    logic       w_shift_free;
    logic       w_accept;
    logic       w_load;
    logic [7:0] w_load_data;

    assign w_frame_end  = (r_bitcnt == 4'd1) && (r_divcnt == '0);
    assign w_shift_free = (r_bitcnt == 4'd0) || w_frame_end;
    assign w_accept     = in_valid && in_ready;
    assign txd          = r_txd;

`ifdef PERIDOT_PHY_TXD_HOLDBUF_EN
    logic       r_hold_full;
    logic [7:0] r_hold_data;

    assign in_ready    = !r_hold_full;
    assign w_load      = w_shift_free && (r_hold_full || w_accept);
    assign w_load_data = r_hold_full ? r_hold_data : in_data;

    // A byte accepted while the shifter is free bypasses the buffer entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
        end else if (w_accept && !w_shift_free) begin
            r_hold_full <= 1'b1;
            r_hold_data <= in_data;
        end else if (w_shift_free && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end
`else
    assign in_ready    = w_shift_free;
    assign w_load      = w_accept;
    assign w_load_data = in_data;
`endif

    // A new load at the end-of-frame point takes priority over returning to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= 4'd0;
            r_divcnt <= '0;
            r_shift  <= 8'hFF;
            r_txd    <= UART_IDLE_LEVEL;
        end else if (w_load) begin
            r_shift  <= w_load_data;
            r_txd    <= ~UART_IDLE_LEVEL;
            r_bitcnt <= bitcnt_t'(UART_FRAME_BITS);
            r_divcnt <= CLOCK_DIVNUM;
        end else if (r_bitcnt != 4'd0) begin
            if (r_divcnt == '0) begin
                r_divcnt <= CLOCK_DIVNUM;
                r_bitcnt <= r_bitcnt - 4'd1;
                if (r_bitcnt >= 4'd3) begin
                    r_txd   <= r_shift[0];
                    r_shift <= {1'b1, r_shift[7:1]};
                end else if (r_bitcnt == 4'd2) begin
                    r_txd <= UART_IDLE_LEVEL;
                end
            end else begin
                r_divcnt <= r_divcnt - div_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_peridot_phy_txd.sv
// Directed bench for peridot_phy_txd at 10 clocks per bit (CLOCK_DIVNUM = 9).
// Frames are given LSB first: bit 0 = start, bits 1..8 = data, bit 9 = stop.
module tb_peridot_phy_txd;

    logic       clk;
    logic       reset_n;
    logic       in_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       txd;

    int n_chk;
    int n_err;

`ifdef PERIDOT_PHY_TXD_HOLDBUF_EN
    localparam bit CHK_RDY = 1'b0;
`else
    localparam bit CHK_RDY = 1'b1;
`endif

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    peridot_phy_txd #(
        .CLOCK_FREQUENCY(1000000),
        .UART_BAUDRATE  (100000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_ready(in_ready),
        .in_valid(in_valid),
        .in_data (in_data),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise valid with a byte while idle; returns just after the accepting edge.
    task automatic start_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        chk("ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called just after an accepting edge; returns just after the edge 100 clocks later.
    task automatic check_frame(input logic [9:0] fr, input logic chk_rdy,
                               input logic nxt_v, input logic [7:0] nxt_d, input logic junk);
        for (int c = 0; c < 100; c++) begin
            chk("frame_txd", 32'(txd), 32'(fr[c / 10]));
            if (chk_rdy)
                chk("frame_ready", 32'(in_ready), (c == 99) ? 32'd1 : 32'd0);
            if (junk && c < 99) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 254));
            end
            if (c == 99) begin
                in_valid = nxt_v;
                in_data  = nxt_d;
            end
            tick();
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA3, 10'b1101000110};
        vecs[2] = '{8'h00, 10'b1000000000};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'h0F, 10'b1000011110};
        vecs[5] = '{8'h81, 10'b1100000010};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_txd", 32'(txd), 32'd1);
            chk("reset_ready", 32'(in_ready), 32'd1);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("idle_txd", 32'(txd), 32'd1);
            chk("idle_ready", 32'(in_ready), 32'd1);
        end

        // Each table entry sent as a single frame with a one-clock valid pulse.
        for (int i = 0; i < 6; i++) begin
            start_byte(vecs[i].data);
            check_frame(vecs[i].frame, CHK_RDY, 1'b0, 8'h00, 1'b0);
            chk("post_frame_txd", 32'(txd), 32'd1);
            tick();
        end

        // Back-to-back: second start bit begins exactly 100 clocks after the first.
        start_byte(8'hA3);
        check_frame(vecs[1].frame, CHK_RDY, 1'b1, 8'h00, 1'b0);
        in_valid = 1'b0;
        check_frame(vecs[2].frame, CHK_RDY, 1'b0, 8'h00, 1'b0);
        tick();

`ifndef PERIDOT_PHY_TXD_HOLDBUF_EN
        // Stall: valid held with junk data while busy; only the byte at acceptance matters.
        start_byte(8'h55);
        check_frame(vecs[0].frame, 1'b1, 1'b1, 8'hFF, 1'b1);
        in_valid = 1'b0;
        check_frame(vecs[3].frame, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
`endif

        // Mid-frame reset at clock 45 of a 0x0F frame.
        start_byte(8'h0F);
        for (int c = 0; c < 45; c++) begin
            chk("pre_rst_txd", 32'(txd), 32'(vecs[4].frame[c / 10]));
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("async_rst_txd", 32'(txd), 32'd1);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_rst_txd", 32'(txd), 32'd1);
        end
        reset_n = 1'b1;
        tick();
        chk("post_rst_txd", 32'(txd), 32'd1);
        start_byte(8'h81);
        check_frame(vecs[5].frame, CHK_RDY, 1'b0, 8'h00, 1'b0);
        tick();

`ifdef PERIDOT_PHY_TXD_HOLDBUF_EN
        begin
            logic [9:0] hb_fr[3];
            logic       s[300];
            int         acc_c;
            logic       drop;
            hb_fr[0] = 10'b1001111000;
            hb_fr[1] = 10'b1110001010;
            hb_fr[2] = 10'b1010110100;
            acc_c = -1;
            in_valid = 1'b1;
            in_data  = 8'h3C;
            chk("hb_ready_idle", 32'(in_ready), 32'd1);
            tick();
            for (int c = 0; c < 300; c++) begin
                s[c] = txd;
                drop = 1'b0;
                if (c == 0) begin
                    chk("hb_ready_c0", 32'(in_ready), 32'd1);
                    in_data = 8'hC5;
                end else if (c == 1) begin
                    chk("hb_full_c1", 32'(in_ready), 32'd0);
                    in_data = 8'h5A;
                end else if (in_valid && in_ready) begin
                    acc_c = c;
                    drop  = 1'b1;
                end
                tick();
                if (drop) in_valid = 1'b0;
            end
            chk("hb_third_accept", 32'(acc_c), 32'd100);
            for (int c = 0; c < 300; c++)
                chk("hb_stream_txd", 32'(s[c]), 32'(hb_fr[c / 100][(c % 100) / 10]));
            in_valid = 1'b0;
        end
`endif

        tick();
        chk("final_idle_txd", 32'(txd), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
